// File: rtl/fifo64_pkg.sv
// Shared sizing constants for the 64-deep distributed-RAM FIFO controller.
package fifo64_pkg;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;
  localparam int PTR_W  = 7;
  localparam int CNT_W  = 7;

endpackage

// File: rtl/fifo64_ptr.sv
// 7-bit wrapping FIFO pointer: 6 address bits plus one wrap bit.
// ptr_next exposes the value the pointer takes at the coming edge when not in reset.
module fifo64_ptr
  import fifo64_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next
);

  logic [PTR_W-1:0] ptr_reg;

  // Natural 7-bit overflow gives the mod-128 wrap and toggles the wrap bit at 63 -> 0.
  assign ptr_next = ptr_reg + {{(PTR_W-1){1'b0}}, inc};
  assign ptr      = ptr_reg;

  // Pointer register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (srst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/fifo64_ram_ctrl.sv
// Synchronous FIFO controller for a bank of WIDTH 64x1 dual-port distributed RAMs.
// The bank writes on the falling edge of CLK and reads asynchronously on RAM_DPRA.
// Optional sticky OVERFLOW/UNDERFLOW outputs are built when FIFO64_ERR_FLAGS_EN is defined.
module fifo64_ram_ctrl
  import fifo64_pkg::*;
#(
  parameter int WIDTH            = 8,
  parameter int ALMOST_FULL_LVL  = 60,
  parameter int ALMOST_EMPTY_LVL = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              WR_EN,
  input  logic              RD_EN,
  output logic [WIDTH-1:0]  DOUT,
  output logic              DOUT_VLD,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [CNT_W-1:0]  COUNT,
  output logic [ADDR_W-1:0] RAM_A,
  output logic [ADDR_W-1:0] RAM_DPRA,
  output logic [WIDTH-1:0]  RAM_D,
  output logic              RAM_WE,
  input  logic [WIDTH-1:0]  RAM_DPO
`ifdef FIFO64_ERR_FLAGS_EN
  ,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
`endif
);

  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(ALMOST_FULL_LVL);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(ALMOST_EMPTY_LVL);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             wr_acc;
  logic             rd_acc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_next;

  logic [CNT_W-1:0] count_reg;
  logic             full_reg;
  logic             empty_reg;
  logic             almost_full_reg;
  logic             almost_empty_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             dout_vld_reg;

  // Requests are qualified by the registered flags; reset blocks both sides.
  assign wr_acc = WR_EN & ~full_reg & ~RST;
  assign rd_acc = RD_EN & ~empty_reg & ~RST;

  fifo64_ptr u_wr_ptr (
    .clk      (CLK),
    .srst     (RST),
    .inc      (wr_acc),
    .ptr      (wr_ptr),
    .ptr_next (wr_ptr_next)
  );

  fifo64_ptr u_rd_ptr (
    .clk      (CLK),
    .srst     (RST),
    .inc      (rd_acc),
    .ptr      (rd_ptr),
    .ptr_next (rd_ptr_next)
  );

  // Pointer difference equals COUNT + wr_acc - rd_acc; the wrap bit separates 0 from 64,
  // so full (addresses equal, wrap bits differ) and empty (pointers equal) follow from it.
  assign count_next = wr_ptr_next - rd_ptr_next;

  // Bank-side write port is combinational so the falling-edge write lands in this cycle.
  assign RAM_A    = wr_ptr[ADDR_W-1:0];
  assign RAM_DPRA = rd_ptr[ADDR_W-1:0];
  assign RAM_WE   = wr_acc;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ram_d
    assign RAM_D[gi] = DIN[gi];
  end

  // Occupancy and all flags registered from the next-state count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
    end else begin
      count_reg        <= count_next;
      full_reg         <= (count_next == FULL_CNT);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_LVL);
      almost_empty_reg <= (count_next <= AE_LVL);
    end
  end

  // Read data capture from the asynchronous dual-port output; holds when no read is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout_reg     <= '0;
      dout_vld_reg <= 1'b0;
    end else begin
      dout_vld_reg <= rd_acc;
      if (rd_acc) begin
        dout_reg <= RAM_DPO;
      end
    end
  end

  assign COUNT        = count_reg;
  assign FULL         = full_reg;
  assign EMPTY        = empty_reg;
  assign ALMOST_FULL  = almost_full_reg;
  assign ALMOST_EMPTY = almost_empty_reg;
  assign DOUT         = dout_reg;
  assign DOUT_VLD     = dout_vld_reg;

`ifdef FIFO64_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;

  // Sticky misuse flags: set by a request against the registered FULL/EMPTY, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (WR_EN && full_reg) begin
        overflow_reg <= 1'b1;
      end
      if (RD_EN && empty_reg) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign OVERFLOW  = overflow_reg;
  assign UNDERFLOW = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo64_ram_ctrl.sv
// Self-checking bench for fifo64_ram_ctrl: includes a behavioural 64xWIDTH RAM bank,
// a queue-based reference model, a hand-computed vector table and directed/random sequences.
module tb_fifo64_ram_ctrl;

  localparam int W   = 8;
  localparam int AFL = 60;
  localparam int AEL = 4;

  logic         CLK;
  logic         RST;
  logic [W-1:0] DIN;
  logic         WR_EN;
  logic         RD_EN;
  logic [W-1:0] DOUT;
  logic         DOUT_VLD;
  logic         FULL;
  logic         EMPTY;
  logic         ALMOST_FULL;
  logic         ALMOST_EMPTY;
  logic [6:0]   COUNT;
  logic [5:0]   RAM_A;
  logic [5:0]   RAM_DPRA;
  logic [W-1:0] RAM_D;
  logic         RAM_WE;
  logic [W-1:0] RAM_DPO;
`ifdef FIFO64_ERR_FLAGS_EN
  logic         OVERFLOW;
  logic         UNDERFLOW;
`endif

  fifo64_ram_ctrl #(
    .WIDTH            (W),
    .ALMOST_FULL_LVL  (AFL),
    .ALMOST_EMPTY_LVL (AEL)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .DIN          (DIN),
    .WR_EN        (WR_EN),
    .RD_EN        (RD_EN),
    .DOUT         (DOUT),
    .DOUT_VLD     (DOUT_VLD),
    .FULL         (FULL),
    .EMPTY        (EMPTY),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY),
    .COUNT        (COUNT),
    .RAM_A        (RAM_A),
    .RAM_DPRA     (RAM_DPRA),
    .RAM_D        (RAM_D),
    .RAM_WE       (RAM_WE),
    .RAM_DPO      (RAM_DPO)
`ifdef FIFO64_ERR_FLAGS_EN
    ,
    .OVERFLOW     (OVERFLOW),
    .UNDERFLOW    (UNDERFLOW)
`endif
  );

  // Clock: period 10
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM bank: falling-edge write, asynchronous dual-port read
  logic [W-1:0] bank [64];
  initial for (int i = 0; i < 64; i++) bank[i] = '0;
  always @(negedge CLK) if (RAM_WE) bank[RAM_A] <= RAM_D;
  assign RAM_DPO = bank[RAM_DPRA];

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout;
  bit           m_vld;
  bit           m_ovf;
  bit           m_udf;

  int checks;
  int errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational write port, advance model, check registers.
  task automatic step(input bit rst, input bit wr, input bit rd, input logic [W-1:0] din,
                      output logic we_seen);
    bit wacc, racc, was_full, was_empty;
    int n;
    RST = rst; WR_EN = wr; RD_EN = rd; DIN = din;
    #1;
    was_full  = (mq.size() == 64);
    was_empty = (mq.size() == 0);
    wacc = wr && !rst && !was_full;
    racc = rd && !rst && !was_empty;
    we_seen = RAM_WE;
    check("ram_we", RAM_WE, wacc);
    if (wacc) check("ram_d", RAM_D, din);
    @(posedge CLK);
    #1;
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      m_vld = racc;
      if (racc) m_dout = mq.pop_front();
      if (wacc) mq.push_back(din);
      if (wr && was_full)  m_ovf = 1'b1;
      if (rd && was_empty) m_udf = 1'b1;
    end
    n = mq.size();
    check("count",        COUNT, n);
    check("empty",        EMPTY, (n == 0));
    check("full",         FULL, (n == 64));
    check("almost_full",  ALMOST_FULL, (n >= AFL));
    check("almost_empty", ALMOST_EMPTY, (n <= AEL));
    check("dout_vld",     DOUT_VLD, m_vld);
    check("dout",         DOUT, m_dout);
`ifdef FIFO64_ERR_FLAGS_EN
    check("overflow",  OVERFLOW, m_ovf);
    check("underflow", UNDERFLOW, m_udf);
`endif
  endtask

  typedef struct {
    bit           rst;
    bit           wr;
    bit           rd;
    logic [W-1:0] din;
    bit           we;
    int           count;
    bit           empty;
    bit           full;
    bit           vld;
    logic [W-1:0] dout;
  } vec_t;

  vec_t vt[8];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic we;
    checks = 0;
    errors = 0;
    m_dout = '0; m_vld = 0; m_ovf = 0; m_udf = 0;

    // Hand-computed vectors, applied right after a reset
    vt[0] = '{0, 1, 0, 8'h11, 1, 1, 0, 0, 0, 8'h00};
    vt[1] = '{0, 1, 0, 8'h22, 1, 2, 0, 0, 0, 8'h00};
    vt[2] = '{0, 1, 1, 8'h33, 1, 2, 0, 0, 1, 8'h11};
    vt[3] = '{0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 8'h22};
    vt[4] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h33};
    vt[5] = '{0, 0, 1, 8'h00, 0, 0, 1, 0, 0, 8'h33};
    vt[6] = '{0, 1, 1, 8'h44, 1, 1, 0, 0, 0, 8'h33};
    vt[7] = '{1, 1, 0, 8'h55, 0, 0, 1, 0, 0, 8'h00};

    RST = 1; WR_EN = 0; RD_EN = 0; DIN = '0;
    @(posedge CLK);
    #1;

    // Reset for two cycles, then idle read against EMPTY
    step(1, 0, 0, '0, we);
    step(1, 0, 0, '0, we);
    check("reset_empty", EMPTY, 1'b1);
    check("reset_count", COUNT, 7'd0);
    check("reset_dout",  DOUT, '0);
    step(0, 0, 1, 8'hAA, we);
    check("idle_rd_vld", DOUT_VLD, 1'b0);
    $display("reset/idle done: count=%0d empty=%0b", COUNT, EMPTY);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].rd, vt[i].din, we);
      check("tbl_we",    we, vt[i].we);
      check("tbl_count", COUNT, vt[i].count);
      check("tbl_empty", EMPTY, vt[i].empty);
      check("tbl_full",  FULL, vt[i].full);
      check("tbl_vld",   DOUT_VLD, vt[i].vld);
      check("tbl_dout",  DOUT, vt[i].dout);
      $display("vec %0d: rst=%0b wr=%0b rd=%0b din=%02h -> we=%0b count=%0d dout=%02h vld=%0b",
               i, vt[i].rst, vt[i].wr, vt[i].rd, vt[i].din, we, COUNT, DOUT, DOUT_VLD);
    end

    // Fill with 0x00..0x3F, then one rejected write
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 0, W'(i), we);
      if (i == AFL - 2) check("af_before_lvl", ALMOST_FULL, 1'b0);
      if (i == AFL - 1) check("af_at_lvl", ALMOST_FULL, 1'b1);
    end
    check("fill_full", FULL, 1'b1);
    step(0, 1, 0, 8'hEE, we);
    check("overfill_we", we, 1'b0);
    check("overfill_count", COUNT, 7'd64);
    $display("fill done: count=%0d full=%0b", COUNT, FULL);

    // Drain in order
    for (int i = 0; i < 64; i++) begin
      step(0, 0, 1, '0, we);
      check("drain_val", DOUT, W'(i));
    end
    check("drain_empty", EMPTY, 1'b1);
    $display("drain done: count=%0d empty=%0b", COUNT, EMPTY);

    // Preload 10, then 200 cycles of simultaneous read/write across the pointer wrap
    for (int i = 0; i < 10; i++) step(0, 1, 0, W'($urandom), we);
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 1, W'($urandom), we);
    end
    check("conc_count", COUNT, 7'd10);
    $display("concurrent phase done: count=%0d", COUNT);

    // Both requests at FULL and at EMPTY
    while (mq.size() < 64) step(0, 1, 0, W'($urandom), we);
    step(0, 1, 1, 8'h5A, we);
    check("full_both_we", we, 1'b0);
    check("full_both_count", COUNT, 7'd63);
    while (mq.size() > 0) step(0, 0, 1, '0, we);
    step(0, 1, 1, 8'hA5, we);
    check("empty_both_vld", DOUT_VLD, 1'b0);
    check("empty_both_count", COUNT, 7'd1);
    $display("full/empty concurrency done: count=%0d", COUNT);

    // Reset mid-stream at COUNT=37 with a write pending
    while (mq.size() < 37) step(0, 1, 0, W'($urandom), we);
    step(1, 1, 0, 8'h77, we);
    check("midrst_we", we, 1'b0);
    check("midrst_count", COUNT, 7'd0);
    check("midrst_empty", EMPTY, 1'b1);
    step(0, 1, 0, 8'h3C, we);
    step(0, 0, 1, '0, we);
    check("post_rst_data", DOUT, 8'h3C);
    $display("mid-stream reset done: count=%0d dout=%02h", COUNT, DOUT);

`ifdef FIFO64_ERR_FLAGS_EN
    // Sticky overflow/underflow
    step(0, 0, 1, '0, we);
    check("underflow_set", UNDERFLOW, 1'b1);
    while (mq.size() < 64) step(0, 1, 0, W'($urandom), we);
    check("no_overflow_yet", OVERFLOW, 1'b0);
    step(0, 1, 0, 8'h99, we);
    check("overflow_set", OVERFLOW, 1'b1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, '0, we);
    check("overflow_hold", OVERFLOW, 1'b1);
    step(1, 0, 0, '0, we);
    check("overflow_clr", OVERFLOW, 1'b0);
    $display("error flag phase done: ovf=%0b udf=%0b", OVERFLOW, UNDERFLOW);
`endif

    // Randomised traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50), W'($urandom), we);
    end
    $display("random phase done: count=%0d", COUNT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
